// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory with combinational fetch read and byte-stream loader
// Words are assembled little-endian from load_data and become readable once the load completes.
module imem_loader #(
  parameter int INSTRUCTION_SIZE = 16,
  parameter int ADDRESS_SIZE = 10,
  parameter logic [INSTRUCTION_SIZE-1:0] NOP_INSTRUCTION = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] pc,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  input  logic                    load_start,
  input  logic [ADDRESS_SIZE:0]   load_length,
  input  logic [7:0]              load_data,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic                    busy,
  output logic                    load_done,
  output logic [ADDRESS_SIZE:0]   loaded_words
);

  localparam int BYTES = INSTRUCTION_SIZE / 8;
  localparam int DEPTH = 2 ** ADDRESS_SIZE;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDRESS_SIZE:0] DEPTH_W = (ADDRESS_SIZE + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDRESS_SIZE:0]       len_q, len_d;
  logic [ADDRESS_SIZE:0]       addr_q, addr_d;
  logic [CNT_W-1:0]            byte_cnt_q, byte_cnt_d;
  logic [INSTRUCTION_SIZE-1:0] asm_q, asm_d;
  logic [ADDRESS_SIZE:0]       loaded_words_q, loaded_words_d;

  logic [INSTRUCTION_SIZE-1:0] mem [DEPTH];
  logic [INSTRUCTION_SIZE-1:0] word_next;
  logic                        start_accept;
  logic                        byte_xfer;
  logic                        word_xfer;

  assign start_accept = (state_q == S_IDLE) && load_start;
  assign byte_xfer    = (state_q == S_LOAD) && load_valid;
  assign word_xfer    = byte_xfer && (byte_cnt_q == LAST_BYTE);

  // Current byte merged into its little-endian slot of the partial word.
  always_comb begin
    word_next = asm_q;
    word_next[8*byte_cnt_q +: 8] = load_data;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = (load_length == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (word_xfer && (addr_q == len_q - 1'b1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      S_LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
      end
      S_DONE: begin
        busy      = 1'b1;
        load_done = 1'b1;
      end
      default: begin
        load_ready = 1'b0;
        busy       = 1'b0;
        load_done  = 1'b0;
      end
    endcase
  end

  // Loader datapath
  always_comb begin
    len_d          = len_q;
    addr_d         = addr_q;
    byte_cnt_d     = byte_cnt_q;
    asm_d          = asm_q;
    loaded_words_d = loaded_words_q;

    if (start_accept) begin
      len_d          = (load_length > DEPTH_W) ? DEPTH_W : load_length;
      addr_d         = '0;
      byte_cnt_d     = '0;
      asm_d          = '0;
      loaded_words_d = '0;
    end

    if (byte_xfer) begin
      if (word_xfer) begin
        byte_cnt_d = '0;
        addr_d     = addr_q + 1'b1;
      end else begin
        asm_d      = word_next;
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end

    if (state_q == S_DONE) begin
      loaded_words_d = len_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q          <= '0;
      addr_q         <= '0;
      byte_cnt_q     <= '0;
      asm_q          <= '0;
      loaded_words_q <= '0;
    end else begin
      len_q          <= len_d;
      addr_q         <= addr_d;
      byte_cnt_q     <= byte_cnt_d;
      asm_q          <= asm_d;
      loaded_words_q <= loaded_words_d;
    end
  end

  // The array is deliberately not reset; loaded_words gates visibility instead.
  always_ff @(posedge clock) begin
    if (word_xfer) begin
      mem[addr_q[ADDRESS_SIZE-1:0]] <= word_next;
    end
  end

  assign loaded_words = loaded_words_q;

  always_comb begin
    instruction = NOP_INSTRUCTION;
    if (!busy && ({1'b0, pc} < loaded_words_q)) begin
      instruction = mem[pc];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
// Expected memory contents and visible word count come from an array model of completed loads.
module tb_imem_loader;

  localparam int IW    = 16;
  localparam int AW    = 10;
  localparam int BYTES = IW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clock;
  logic          reset;
  logic [AW-1:0] pc;
  logic [IW-1:0] instruction;
  logic          load_start;
  logic [AW:0]   load_length;
  logic [7:0]    load_data;
  logic          load_valid;
  logic          load_ready;
  logic          busy;
  logic          load_done;
  logic [AW:0]   loaded_words;

  imem_loader #(
    .INSTRUCTION_SIZE(IW),
    .ADDRESS_SIZE(AW),
    .NOP_INSTRUCTION('0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pc(pc),
    .instruction(instruction),
    .load_start(load_start),
    .load_length(load_length),
    .load_data(load_data),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .busy(busy),
    .load_done(load_done),
    .loaded_words(loaded_words)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [IW-1:0] stim_words [DEPTH];
  logic [IW-1:0] model_mem  [DEPTH];
  int            model_loaded = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_one(input int p);
    logic [IW-1:0] exp;
    pc = AW'(p);
    #1;
    exp = (p < model_loaded) ? model_mem[p] : '0;
    check_eq($sformatf("read_pc%0d", p), 32'(instruction), 32'(exp));
  endtask

  task automatic check_reads();
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("loaded_words", 32'(loaded_words), 32'(model_loaded));
    for (int p = 0; p < 5; p++) read_one(p);
    if (model_loaded > 0) read_one(model_loaded - 1);
    if (model_loaded < DEPTH) read_one(model_loaded);
    read_one(DEPTH - 1);
    repeat (4) read_one(int'($urandom_range(0, DEPTH - 1)));
  endtask

  // gap_mode: 0 none, 1 two idle cycles before every byte, 2 random 0..2 idle cycles
  task automatic do_load(input int n, input int gap_mode, input int pulse_at);
    int n_eff, busy_cnt, exp_busy, ready_bad, done_early, g;
    n_eff = (n > DEPTH) ? DEPTH : n;
    @(negedge clock);
    load_start  = 1'b1;
    load_length = (AW + 1)'(n);
    @(negedge clock);
    load_start = 1'b0;
    if (n_eff == 0) begin
      check_eq("zero_done_pulse", 32'(load_done), 32'd1);
      check_eq("zero_ready", 32'(load_ready), 32'd0);
      @(negedge clock);
      check_eq("zero_done_clear", 32'(load_done), 32'd0);
      model_loaded = 0;
      return;
    end
    busy_cnt = 0; exp_busy = 0; ready_bad = 0; done_early = 0;
    for (int i = 0; i < n_eff * BYTES; i++) begin
      g = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        if (busy) busy_cnt++;
        if (!load_ready) ready_bad++;
        if (load_done) done_early++;
        exp_busy++;
        @(negedge clock);
      end
      load_valid = 1'b1;
      load_data  = stim_words[i / BYTES][8*(i % BYTES) +: 8];
      if (i == pulse_at) begin
        load_start  = 1'b1;
        load_length = (AW + 1)'($urandom);
      end
      if (busy) busy_cnt++;
      if (!load_ready) ready_bad++;
      if (load_done) done_early++;
      exp_busy++;
      @(negedge clock);
      load_start = 1'b0;
    end
    load_valid = 1'b0;
    check_eq("done_pulse", 32'(load_done), 32'd1);
    check_eq("done_ready_low", 32'(load_ready), 32'd0);
    if (busy) busy_cnt++;
    exp_busy++;
    check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    check_eq("ready_low_in_load", 32'(ready_bad), 32'd0);
    check_eq("done_early", 32'(done_early), 32'd0);
    @(negedge clock);
    check_eq("done_clear", 32'(load_done), 32'd0);
    for (int w = 0; w < n_eff; w++) model_mem[w] = stim_words[w];
    model_loaded = n_eff;
  endtask

  initial begin
    reset = 1'b0; pc = '0; load_start = 1'b0; load_length = '0;
    load_data = '0; load_valid = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(load_ready), 32'd0);
    check_eq("rst_done", 32'(load_done), 32'd0);
    check_eq("rst_loaded", 32'(loaded_words), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check_reads();

    stim_words[0] = 16'h1234; stim_words[1] = 16'h5678; stim_words[2] = 16'h9ABC;
    do_load(3, 0, -1);
    check_reads();

    do_load(3, 1, -1);
    check_reads();

    do_load(0, 0, -1);
    check_reads();

    // Reset part-way through a two-word load, after three bytes.
    stim_words[0] = 16'hA1B2; stim_words[1] = 16'hC3D4;
    @(negedge clock);
    load_start = 1'b1; load_length = 11'd2;
    @(negedge clock);
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = stim_words[i / BYTES][8*(i % BYTES) +: 8];
      @(negedge clock);
    end
    load_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ready", 32'(load_ready), 32'd0);
    model_loaded = 0;
    read_one(0);
    @(negedge clock);
    reset = 1'b1;
    stim_words[0] = 16'hBEEF;
    do_load(1, 0, -1);
    check_reads();

    repeat (4) begin
      int n;
      n = int'($urandom_range(1, 40));
      for (int w = 0; w < n; w++) stim_words[w] = IW'($urandom);
      do_load(n, 2, -1);
      check_reads();
    end

    for (int w = 0; w < DEPTH; w++) stim_words[w] = IW'($urandom);
    do_load(DEPTH + 1, 0, 1000);
    check_reads();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
